// File: rtl/fc_argmax_if.sv
// Handshake and picture-memory read bus between fc_argmax and its surroundings.
// The master modport is the argmax block. The slave modport is the scheduler/memory side.
interface fc_argmax_if #(
  parameter int ADDR_BIT = 10,
  parameter int DATA_BIT = 16
);
  logic                start;
  logic                mem_rd_en;
  logic [ADDR_BIT-1:0] mem_addr;
  logic [DATA_BIT-1:0] mem_rd_data;
  logic                busy;
  logic                done;
  logic                result_valid;
  logic [3:0]          class_idx;
  logic [DATA_BIT-1:0] class_score;

  modport master (
    input  start, mem_rd_data,
    output mem_rd_en, mem_addr, busy, done, result_valid, class_idx, class_score
  );

  modport slave (
    output start, mem_rd_data,
    input  mem_rd_en, mem_addr, busy, done, result_valid, class_idx, class_score
  );
endinterface

// File: rtl/fc_argmax.sv
// Sweeps NUM_CLASS signed FC scores out of picture memory and reports the argmax.
// A read issued in FETCH returns one cycle later and is tagged with its index for the compare stage.
module fc_argmax #(
  parameter int ADDR_BIT  = 10,
  parameter int DATA_BIT  = 16,
  parameter int BASE_ADDR = 16,
  parameter int NUM_CLASS = 10
) (
  input  logic         clk,
  input  logic         rst,
  fc_argmax_if.master  bus
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FETCH = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  localparam logic [3:0] K_LAST = 4'(NUM_CLASS - 1);

  logic [1:0]                 state_q, state_d;
  logic [3:0]                 k_q, k_d;
  logic                       tag_vld_q, tag_vld_d;
  logic [3:0]                 tag_idx_q, tag_idx_d;
  logic signed [DATA_BIT-1:0] max_val_q, max_val_d;
  logic [3:0]                 max_idx_q, max_idx_d;
  logic                       rv_q, rv_d;
  logic signed [DATA_BIT-1:0] rd_word;

  assign rd_word = $signed(bus.mem_rd_data);

  always_comb begin
    state_d   = state_q;
    k_d       = k_q;
    rv_d      = rv_q;
    max_val_d = max_val_q;
    max_idx_d = max_idx_q;
    tag_vld_d = (state_q == ST_FETCH);
    tag_idx_d = k_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          state_d   = ST_FETCH;
          k_d       = '0;
          rv_d      = 1'b0;
          max_val_d = '0;
          max_idx_d = '0;
        end
      end
      ST_FETCH: begin
        k_d = k_q + 4'd1;
        if (k_q == K_LAST) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        state_d = ST_DONE;
        rv_d    = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase

    // Strict greater-than keeps the earliest index on ties; index 0 seeds the running max.
    if (tag_vld_q && ((tag_idx_q == 4'd0) || (rd_word > max_val_q))) begin
      max_val_d = rd_word;
      max_idx_d = tag_idx_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      k_q       <= '0;
      tag_vld_q <= 1'b0;
      tag_idx_q <= '0;
      max_val_q <= '0;
      max_idx_q <= '0;
      rv_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      k_q       <= k_d;
      tag_vld_q <= tag_vld_d;
      tag_idx_q <= tag_idx_d;
      max_val_q <= max_val_d;
      max_idx_q <= max_idx_d;
      rv_q      <= rv_d;
    end
  end

  assign bus.mem_rd_en    = (state_q == ST_FETCH);
  assign bus.mem_addr     = bus.mem_rd_en ? (ADDR_BIT'(BASE_ADDR) + ADDR_BIT'(k_q)) : '0;
  assign bus.busy         = (state_q != ST_IDLE);
  assign bus.done         = (state_q == ST_DONE);
  assign bus.result_valid = rv_q;
  assign bus.class_idx    = max_idx_q;
  assign bus.class_score  = max_val_q;

endmodule

// File: tb/tb_fc_argmax.sv
// Self-checking bench for fc_argmax: registered picture-memory model plus a plain argmax reference.
module tb_fc_argmax;
  localparam int AB = 10, DB = 16, BASE = 16, NC = 10;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fc_argmax_if #(.ADDR_BIT(AB), .DATA_BIT(DB)) bus();
  fc_argmax #(.ADDR_BIT(AB), .DATA_BIT(DB), .BASE_ADDR(BASE), .NUM_CLASS(NC))
    dut (.clk(clk), .rst(rst), .bus(bus));

  logic signed [DB-1:0] mem [0:1023];

  // Read data valid one cycle after the address; garbage otherwise to expose mistimed sampling.
  always @(posedge clk)
    bus.mem_rd_data <= bus.mem_rd_en ? mem[bus.mem_addr] : DB'($urandom);

  int checks = 0, errors = 0;

  logic signed [DB-1:0] sc [NC];
  int                   ref_idx;
  logic signed [DB-1:0] ref_val;

  int                   done_cyc, busy_n, addr_leak;
  logic [3:0]           got_idx;
  logic signed [DB-1:0] got_sc;
  logic                 got_rv;
  int                   addr_q[$];
  int                   acyc_q[$];

  task automatic load_ref();
    for (int i = 0; i < NC; i++) mem[BASE+i] = sc[i];
    ref_val = sc[0];
    for (int i = 1; i < NC; i++) if (sc[i] > ref_val) ref_val = sc[i];
    ref_idx = -1;
    for (int i = NC - 1; i >= 0; i--) if (sc[i] == ref_val) ref_idx = i;
  endtask

  task automatic set_scores(input int v[NC]);
    for (int i = 0; i < NC; i++) sc[i] = DB'(v[i]);
    load_ref();
  endtask

  // Starts a run in the next IDLE cycle and records what the DUT does up to its done pulse.
  task automatic do_run();
    @(negedge clk);
    bus.start = 1'b1;
    addr_q.delete(); acyc_q.delete();
    done_cyc = -1; busy_n = 0; addr_leak = 0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      bus.start = 1'b0;
      if (bus.mem_rd_en) begin addr_q.push_back(int'(bus.mem_addr)); acyc_q.push_back(c); end
      else if (bus.mem_addr != '0) addr_leak++;
      if (bus.busy) busy_n++;
      if (bus.done) begin
        done_cyc = c; got_idx = bus.class_idx; got_sc = bus.class_score; got_rv = bus.result_valid;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; bus.start = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({bus.mem_rd_en, bus.busy, bus.done, bus.result_valid} !== 4'b0 ||
        bus.mem_addr !== '0 || bus.class_idx !== 4'd0 || bus.class_score !== '0) begin
      errors++;
      $display("FAIL reset: en=%b addr=%0d busy=%b done=%b rv=%b idx=%0d score=%0d, want all 0",
               bus.mem_rd_en, bus.mem_addr, bus.busy, bus.done, bus.result_valid, bus.class_idx, bus.class_score);
    end
    rst = 1'b0;
  endtask

  task automatic test_basic();
    int bad;
    set_scores('{3, -1, 7, 2, 0, 5, 1, 9, 4, 6});
    do_run();
    checks++;
    if (done_cyc !== NC + 2) begin errors++; $display("FAIL basic_latency: done at %0d, want %0d", done_cyc, NC + 2); end
    checks++;
    if (got_idx !== 4'(ref_idx) || got_sc !== ref_val || got_rv !== 1'b1) begin
      errors++; $display("FAIL basic_result: idx=%0d score=%0d rv=%b, want idx=%0d score=%0d rv=1", got_idx, got_sc, got_rv, ref_idx, ref_val);
    end
    bad = (addr_q.size() != NC) ? 1 : 0;
    for (int i = 0; i < addr_q.size() && i < NC; i++) if (addr_q[i] != BASE + i || acyc_q[i] != i + 1) bad++;
    checks++;
    if (bad != 0 || addr_leak != 0) begin
      errors++; $display("FAIL basic_addr: %0d reads, %0d bad, %0d idle addr nonzero, want %0d reads at %0d.. in cycles 1..%0d", addr_q.size(), bad, addr_leak, NC, BASE, NC);
    end
    checks++;
    if (busy_n != NC + 2) begin errors++; $display("FAIL basic_busy: busy cycles %0d, want %0d", busy_n, NC + 2); end
    bad = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.result_valid !== 1'b1 || bus.class_idx !== 4'd7 || bus.class_score !== 16'sd9) bad++;
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL basic_hold: %0d idle cycles lost result, want 0", bad); end
  endtask

  task automatic test_negative();
    set_scores('{-5, -3, -8, -100, -4, -9, -7, -6, -32768, -10});
    do_run();
    checks++;
    if (done_cyc !== NC + 2 || got_idx !== 4'd1 || got_sc !== -16'sd3) begin
      errors++; $display("FAIL negative: done=%0d idx=%0d score=%0d, want done=%0d idx=1 score=-3", done_cyc, got_idx, got_sc, NC + 2);
    end
  endtask

  task automatic test_tie();
    set_scores('{0, 0, 20, 0, 0, 0, 0, 0, 20, 0});
    do_run();
    checks++;
    if (got_idx !== 4'd2 || got_sc !== 16'sd20) begin
      errors++; $display("FAIL tie: idx=%0d score=%0d, want idx=2 score=20", got_idx, got_sc);
    end
  endtask

  task automatic test_boundary();
    for (int i = 0; i < NC; i++) sc[i] = DB'($urandom_range(0, 65535));
    for (int i = 0; i < NC; i++) if (sc[i] == 16'sh7fff) sc[i] = 16'sd0;
    sc[0] = 16'sh7fff; load_ref();
    do_run();
    checks++;
    if (got_idx !== 4'd0 || got_sc !== 16'sh7fff) begin
      errors++; $display("FAIL boundary_first: idx=%0d score=%0d, want idx=0 score=32767", got_idx, got_sc);
    end
    for (int i = 0; i < NC; i++) if (sc[i] == 16'sh7fff) sc[i] = -16'sd1;
    sc[NC-1] = 16'sh7fff; load_ref();
    do_run();
    checks++;
    if (got_idx !== 4'(NC - 1) || got_sc !== mem[BASE+NC-1] || addr_q.size() != NC || addr_q[NC-1] != BASE + NC - 1) begin
      errors++; $display("FAIL boundary_last: idx=%0d score=%0d reads=%0d, want idx=%0d score=32767 last addr %0d", got_idx, got_sc, addr_q.size(), NC - 1, BASE + NC - 1);
    end
  endtask

  // Back-to-back runs: each starts in the first IDLE cycle after the previous done.
  task automatic test_back_to_back();
    for (int r = 0; r < 8; r++) begin
      for (int i = 0; i < NC; i++)
        sc[i] = (r % 2 == 0) ? DB'($urandom) : DB'(int'($urandom_range(0, 6)) - 3);
      load_ref();
      do_run();
      checks++;
      if (done_cyc !== NC + 2 || got_idx !== 4'(ref_idx) || got_sc !== ref_val) begin
        errors++; $display("FAIL random_run%0d: done=%0d idx=%0d score=%0d, want done=%0d idx=%0d score=%0d", r, done_cyc, got_idx, got_sc, NC + 2, ref_idx, ref_val);
      end
    end
  endtask

  task automatic test_hold_start();
    int bad_done, bad_rv, ndone;
    logic [3:0] idx0;
    set_scores('{1, 2, 3, 4, 5, 6, 7, 8, 9, 10});
    @(negedge clk);
    bus.start = 1'b1;
    bad_done = 0; bad_rv = 0; idx0 = '0;
    for (int c = 1; c < 30; c++) begin
      @(negedge clk);
      if (bus.done !== ((c == 12) || (c == 25))) bad_done++;
      if (c >= 14 && c <= 24 && bus.result_valid !== 1'b0) bad_rv++;
      if (c == 25) idx0 = bus.class_idx;
    end
    bus.start = 1'b0;
    checks++;
    if (bad_done != 0) begin errors++; $display("FAIL hold_done: %0d cycles with wrong done, want done only at 12 and 25", bad_done); end
    checks++;
    if (bad_rv != 0 || idx0 !== 4'd9) begin errors++; $display("FAIL hold_rv: %0d busy cycles with rv high, idx=%0d, want 0 and idx 9", bad_rv, idx0); end
    ndone = 0;
    for (int c = 0; c < 20 && ndone == 0; c++) begin @(negedge clk); if (bus.done) ndone++; end
    checks++;
    if (ndone != 1) begin errors++; $display("FAIL hold_drain: trailing run done count %0d, want 1", ndone); end
  endtask

  task automatic test_ignore_start();
    int ndone, busy13;
    set_scores('{0, 0, 0, 0, 0, 0, -2, 5, 0, 0});
    @(negedge clk);
    bus.start = 1'b1;
    ndone = 0; busy13 = 0;
    for (int c = 1; c <= 30; c++) begin
      @(negedge clk);
      if (bus.done) ndone += (c == 12) ? 1 : 100;
      if (c == 13) busy13 = int'(bus.busy);
      bus.start = (c == 3) || (c == 12);
    end
    bus.start = 1'b0;
    checks++;
    if (ndone != 1 || busy13 != 0 || bus.class_idx !== 4'd7) begin
      errors++; $display("FAIL ignore_start: done code %0d busy@13=%0d idx=%0d, want 1 0 7", ndone, busy13, bus.class_idx);
    end
  endtask

  task automatic test_reset_midrun();
    int bad, nd;
    set_scores('{4, 4, 4, 4, 4, 4, 4, 4, 4, 11});
    @(negedge clk);
    bus.start = 1'b1;
    bad = 0; nd = 0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      bus.start = 1'b0;
      if (c == 6) begin
        if ({bus.mem_rd_en, bus.busy, bus.done, bus.result_valid} !== 4'b0 ||
            bus.mem_addr !== '0 || bus.class_idx !== 4'd0 || bus.class_score !== '0) bad++;
      end
      if (bus.done) nd++;
      rst = (c == 5);
    end
    checks++;
    if (bad != 0 || nd != 0) begin errors++; $display("FAIL reset_mid: outputs nonzero=%0d dones=%0d, want 0 0", bad, nd); end
    do_run();
    checks++;
    if (done_cyc !== NC + 2 || got_idx !== 4'(ref_idx) || got_sc !== ref_val) begin
      errors++; $display("FAIL reset_rerun: done=%0d idx=%0d score=%0d, want done=%0d idx=%0d score=%0d", done_cyc, got_idx, got_sc, NC + 2, ref_idx, ref_val);
    end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = '0;
    test_reset();
    test_basic();
    test_negative();
    test_tie();
    test_boundary();
    test_back_to_back();
    test_hold_start();
    test_ignore_start();
    test_reset_midrun();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
